mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single-port 256x16 synchronous data/instruction memory between the CPU (port 0) and a secondary master (port 1: program loader / debug DMA). It grants at most one access per cycle, drives the memory address/data/write-enable, and returns read data one cycle later tagged to the requester that issued the read. It sits between `CPU_top`'s `address`/`data_out`/`wea`/`data_in` bus and the memory macro.

## Interface
- `AW`, 8, address width (256 words)
- `DW`, 16, data width
- `LOCK_MAX`, 4, max consecutive locked grants to port 1 while port 0 is waiting (1..15)

- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request; hold with address/data stable until granted
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  AW  word address
- `m0_wdata`, `m1_wdata`  in  DW  write data
- `m1_lock`  in  1  port 1 requests back-to-back grants (burst)
- `m0_gnt`, `m1_gnt`  out  1  combinational grant; access is taken at the edge where req&gnt
- `m0_rvalid`, `m1_rvalid`  out  1  registered; read data valid this cycle
- `m0_rdata`, `m1_rdata`  out  DW  = `mem_rdata`, qualified by rvalid
- `mem_addr`  out  AW  to memory
- `mem_wdata`  out  DW  to memory
- `mem_we`  out  1  memory write enable
- `mem_rdata`  in  DW  memory read data, 1-cycle latency after address sampled

## Operation
- State: `last` (port granted most recently, reset 1), `rd_tag` (valid + port of read issued last cycle), `lock_cnt` (4-bit), `locked` flag.
- Grant selection each cycle (combinational from req and state):
  - `locked` and `m1_req` and (`!m0_req` or `lock_cnt < LOCK_MAX`) -> port 1.
  - else both request -> priority rule (see Configuration).
  - else the single requester; none -> no grant.
- Exactly one of `m0_gnt`/`m1_gnt` high at most; never high without matching req.
- Memory bus = muxed fields of granted port; `mem_we` = granted port's we; no grant -> `mem_addr`/`mem_wdata` hold port 0 fields, `mem_we`=0.
- On edge with a granted read: `rd_tag` <= {1, port}; next cycle that port's rvalid=1. Otherwise rd_tag valid <= 0. Writes produce no rvalid.
- Lock: port 1 granted with `m1_lock`=1 -> `locked`<=1, `lock_cnt`<=lock_cnt+1 (saturating at 15). Lock released (locked<=0, cnt<=0) when port 1 not granted, `m1_lock`=0, or `m1_req`=0. `lock_cnt` increments only on cycles where m0_req is high; it counts cycles port 0 is starved.
- `last` updates to granted port on every granted edge.

## Timing
- Reset (async assert, sync deassert by system): gnt=0 (no req after reset anyway), rvalid=0, `rd_tag`=invalid, `last`=1, `locked`=0, `lock_cnt`=0, `mem_we`=0. Reset mid-read drops the pending rvalid.
- Grant latency: 0 cycles (same cycle as req if selected). Read data latency: 1 cycle after granting edge.
- Back-to-back reads from alternating ports: one access per cycle, rvalids alternate, no bubbles.
- Simultaneous read by one port and write by other: serialized per priority; loser stalls with req held.
- Read-after-write same address, consecutive cycles: read returns new data (memory write-first assumed at macro).
- Starvation bound: port 0 waits at most `LOCK_MAX` cycles under port 1 lock, then gets one grant.

## Configuration
- `MEM_ARB_RR_EN` defined: contention resolved round-robin; winner = port != `last`.
- Undefined: fixed priority, port 0 (CPU) always wins contention; `last` still maintained but unused for selection. Lock behaviour identical in both builds.

## Structure
- Package `mem_arb_pkg`: `AW`, `DW` defaults, `LOCK_MAX` default, port index localparams `PORT_CPU`=0, `PORT_AUX`=1, `rd_tag` struct (valid, port).
- One sub-module: `arb_pick2` — combinational 2-way picker (req[1:0], last, rr_en) -> onehot grant; lock override stays in `mem_arbiter`.

## Test plan
- Reset with m0 read addr 50 pending -> after release, m0_gnt same cycle, next cycle m0_rvalid=1, m0_rdata=0x0001 (mem[50]=1).
- Both request reads (m0 addr 51, m1 addr 52) continuously, RR build -> grants alternate m0,m1,...; rvalid tags m0=0x0002, m1=0x0003; fixed build -> m1 never granted while m0_req high.
- m1 write 0xBEEF to addr 100 while m0 reads addr 100 same cycle, fixed build -> m0 reads old value 0x0000, m1 granted next cycle, subsequent m0 read returns 0xBEEF.
- m1 burst with m1_lock=1, m0_req held, LOCK_MAX=4 -> m1 granted 4 consecutive cycles, m0 granted on 5th, mem_we tracks granted port only.
- Reset asserted in the cycle after a granted read -> rvalid stays 0, no grants, mem_we=0 until req re-presented.
- No requests for 10 cycles -> gnt=0, mem_we=0, rvalid=0 throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared defaults, port indices and read-tag type for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF       = 8;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned LOCK_MAX_DEF = 4;
    localparam int unsigned CNT_W        = 4;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    // Saturating increment for the starvation counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_arbiter_pick2.sv
// Combinational 2-way picker: a lone request wins outright; contention goes to port 0,
// or to the port that was not granted last when round-robin is enabled.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            if (rr_en && !last) begin
                gnt = 2'b10;
            end else begin
                gnt = 2'b01;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the CPU (port 0) and an aux master (port 1).
// Define MEM_ARB_RR_EN for round-robin contention; default build gives port 0 fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

`ifdef MEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    rd_tag_t          rd_tag;
    logic             last;
    logic             locked;
    logic [CNT_W-1:0] lock_cnt;
    logic [1:0]       pick_gnt;
    logic [1:0]       gnt;
    logic             lock_hold;

    arb_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .rr_en (RR_EN),
        .gnt   (pick_gnt)
    );

    // A locked burst keeps port 1 until port 0 has been starved LOCK_MAX cycles.
    always_comb begin
        lock_hold = locked && m1_req && (!m0_req || (lock_cnt < CNT_W'(LOCK_MAX)));
        gnt       = lock_hold ? 2'b10 : pick_gnt;
    end

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Memory bus follows the granted port; idle bus parks on port 0 fields.
    always_comb begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_we    = 1'b0;
        if (gnt[1]) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
        end else if (gnt[0]) begin
            mem_we = m0_we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_tag   <= '0;
            last     <= PORT_AUX;
            locked   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            rd_tag.valid <= (|gnt) && !mem_we;
            rd_tag.port  <= gnt[1];
            if (|gnt) begin
                last <= gnt[1];
            end
            // Starvation is only counted while port 0 is actually waiting.
            if (gnt[1] && m1_lock) begin
                locked <= 1'b1;
                if (m0_req) begin
                    lock_cnt <= sat_inc(lock_cnt);
                end
            end else begin
                locked   <= 1'b0;
                lock_cnt <= '0;
            end
        end
    end

    assign m0_rvalid = rd_tag.valid && (rd_tag.port == PORT_CPU);
    assign m1_rvalid = rd_tag.valid && (rd_tag.port == PORT_AUX);
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant table, directed corner sequences, randomized model check.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned AW = AW_DEF;
    localparam int unsigned DW = DW_DEF;
    localparam int unsigned LM = LOCK_MAX_DEF;
`ifdef MEM_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m1_req, m0_we, m1_we, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return (i >= 50 && i < 100) ? DW'(i - 49) : '0;
    endfunction

    // Write-first synchronous memory; contents reload while reset is low.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1, input logic lk,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        m0_req = r0; m1_req = r1; m0_we = w0; m1_we = w1; m1_lock = lk;
        m0_addr = a0; m1_addr = a1; m0_wdata = d0; m1_wdata = d1;
    endtask

    typedef struct {
        logic       r0, r1, w0, w1, lk;
        logic [1:0] g_fix, g_rr;
        logic       we_fix, we_rr;
    } vec_t;
    vec_t tbl [12];

    // Reference model state for the random phase.
    logic [DW-1:0] ref_mem [256];
    int            win;
    int unsigned   starve;
    logic          burst, mlast;
    logic          exp_rv, exp_rport;
    logic [DW-1:0] exp_rdat;
    logic          p0, p1, rw0, rw1, rlk;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0, rd1;
    logic [1:0]    eg;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        step(); step();
        @(negedge clk);
        check("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        check("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        step();
        rst_n = 1'b1;

        // Grant table from a fresh reset (last = port 1, unlocked).
        tbl[0]  = '{0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 2'b10, 2'b10, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 2'b01, 2'b01, 0, 0};
        tbl[4]  = '{1, 1, 0, 0, 0, 2'b01, 2'b10, 0, 0};
        tbl[5]  = '{1, 1, 0, 1, 0, 2'b01, 2'b01, 0, 0};
        tbl[6]  = '{1, 1, 1, 0, 0, 2'b01, 2'b10, 1, 0};
        tbl[7]  = '{0, 1, 0, 0, 1, 2'b10, 2'b10, 0, 0};
        tbl[8]  = '{1, 1, 0, 0, 1, 2'b10, 2'b10, 0, 0};
        tbl[9]  = '{0, 1, 0, 1, 0, 2'b10, 2'b10, 1, 1};
        tbl[10] = '{1, 1, 0, 0, 0, 2'b01, 2'b01, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0};
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].lk, 8'd200, 8'd201, 16'hAAAA, 16'h5555);
            @(negedge clk);
            check($sformatf("tbl%0d_gnt", i), 32'({m1_gnt, m0_gnt}), 32'(RR ? tbl[i].g_rr : tbl[i].g_fix));
            check($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(RR ? tbl[i].we_rr : tbl[i].we_fix));
            step();
        end

        // Read pending across reset release is granted immediately.
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 8'd50, '0, '0, '0);
        @(negedge clk);
        check("rstA_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        check("A_gnt", 32'({m1_gnt, m0_gnt}), 32'b01);
        check("A_addr", 32'(mem_addr), 32'd50);
        step();
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        @(negedge clk);
        check("A_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'b01);
        check("A_rdata", 32'(m0_rdata), 32'h0001);
        step();

        // Continuous contention for reads: last = port 0 here.
        drive(1, 1, 0, 0, 0, 8'd51, 8'd52, '0, '0);
        for (int i = 0; i < 8; i++) begin
            int ew;
            ew = (RR && (i % 2 == 0)) ? 1 : 0;
            @(negedge clk);
            check($sformatf("B%0d_gnt", i), 32'({m1_gnt, m0_gnt}), (ew == 1) ? 32'b10 : 32'b01);
            if (i == 0) begin
                check("B0_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
            end else begin
                int pw;
                pw = (RR && ((i - 1) % 2 == 0)) ? 1 : 0;
                check($sformatf("B%0d_rvalid", i), 32'({m1_rvalid, m0_rvalid}), (pw == 1) ? 32'b10 : 32'b01);
                check($sformatf("B%0d_rdata", i), (pw == 1) ? 32'(m1_rdata) : 32'(m0_rdata),
                      (pw == 1) ? 32'h3 : 32'h2);
            end
            step();
        end
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        step();

        // Same-address read vs write contention after reset.
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        drive(1, 1, 0, 1, 0, 8'd100, 8'd100, '0, 16'hBEEF);
        @(negedge clk);
        check("C1_gnt", 32'({m1_gnt, m0_gnt}), 32'b01);
        check("C1_we", 32'(mem_we), 32'd0);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        check("C2_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'b01);
        check("C2_rdata", 32'(m0_rdata), 32'h0000);
        check("C2_gnt", 32'({m1_gnt, m0_gnt}), 32'b10);
        check("C2_bus", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 8'd100, 16'hBEEF}));
        step();
        drive(1, 0, 0, 0, 0, 8'd100, '0, '0, '0);
        @(negedge clk);
        check("C3_gnt", 32'({m1_gnt, m0_gnt}), 32'b01);
        check("C3_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        check("C4_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'b01);
        check("C4_rdata", 32'(m0_rdata), 32'hBEEF);
        step();

        // Locked burst from port 1 while port 0 waits.
        drive(0, 1, 0, 1, 1, 8'd51, 8'd150, '0, 16'h1234);
        @(negedge clk);
        check("D0_gnt", 32'({m1_gnt, m0_gnt}), 32'b10);
        check("D0_we", 32'(mem_we), 32'd1);
        step();
        m0_req = 1'b1;
        for (int k = 1; k <= int'(LM) + 1; k++) begin
            @(negedge clk);
            check($sformatf("D%0d_gnt", k), 32'({m1_gnt, m0_gnt}), (k <= int'(LM)) ? 32'b10 : 32'b01);
            check($sformatf("D%0d_we", k), 32'(mem_we), (k <= int'(LM)) ? 32'd1 : 32'd0);
            step();
        end
        m0_req = 1'b0;
        @(negedge clk);
        check("D_after_gnt", 32'({m1_gnt, m0_gnt}), 32'b10);
        check("D_after_rdata", 32'({m0_rvalid, m0_rdata}), 32'({1'b1, 16'h0002}));
        step();

        // Reset lands one cycle after a granted read.
        drive(1, 0, 0, 0, 0, 8'd52, '0, '0, '0);
        @(negedge clk);
        check("E_gnt", 32'({m1_gnt, m0_gnt}), 32'b01);
        step();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, '0, '0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("E_rst%0d", i), 32'({m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid}), 32'd0);
            step();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("F_idle%0d", i), 32'({m0_gnt, m1_gnt, mem_we, m0_rvalid, m1_rvalid}), 32'd0);
            step();
        end

        // Randomized traffic against a behavioural model.
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        mlast = 1'b1; burst = 1'b0; starve = 0; exp_rv = 1'b0; exp_rport = 1'b0; exp_rdat = '0;
        p0 = 1'b0; p1 = 1'b0; rw0 = 0; rw1 = 0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!p0 && $urandom_range(0, 9) < 6) begin
                p0 = 1'b1; rw0 = ($urandom_range(0, 2) == 0);
                ra0 = AW'($urandom_range(0, 63)); rd0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(0, 9) < 6) begin
                p1 = 1'b1; rw1 = ($urandom_range(0, 2) == 0);
                ra1 = AW'($urandom_range(0, 63)); rd1 = DW'($urandom);
            end
            rlk = ($urandom_range(0, 9) < 7);
            drive(p0, p1, rw0, rw1, rlk, ra0, ra1, rd0, rd1);

            if (burst && p1 && (!p0 || starve < LM)) win = 1;
            else if (p0 && p1) win = (RR && !mlast) ? 1 : 0;
            else if (p0) win = 0;
            else if (p1) win = 1;
            else win = -1;
            eg = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;

            @(negedge clk);
            check("R_gnt", 32'({m1_gnt, m0_gnt}), 32'(eg));
            check("R_we", 32'(mem_we), 32'((win == 0) ? rw0 : (win == 1) ? rw1 : 1'b0));
            if (win >= 0) check("R_addr", 32'(mem_addr), 32'((win == 1) ? ra1 : ra0));
            if (win >= 0 && ((win == 1) ? rw1 : rw0)) check("R_wdata", 32'(mem_wdata), 32'((win == 1) ? rd1 : rd0));
            check("R_rvalid", 32'({m1_rvalid, m0_rvalid}),
                  32'(exp_rv ? (exp_rport ? 2'b10 : 2'b01) : 2'b00));
            if (exp_rv) check("R_rdata", exp_rport ? 32'(m1_rdata) : 32'(m0_rdata), 32'(exp_rdat));
            step();

            exp_rv = 1'b0;
            if (win >= 0) begin
                mlast = (win == 1);
                if (win == 1) begin
                    if (rw1) ref_mem[ra1] = rd1;
                    else begin exp_rv = 1'b1; exp_rport = 1'b1; exp_rdat = ref_mem[ra1]; end
                    p1 = 1'b0;
                end else begin
                    if (rw0) ref_mem[ra0] = rd0;
                    else begin exp_rv = 1'b1; exp_rport = 1'b0; exp_rdat = ref_mem[ra0]; end
                    p0 = 1'b0;
                end
            end
            if (win == 1 && rlk) begin
                burst = 1'b1;
                if (m0_req && starve < 15) starve++;
            end else begin
                burst = 1'b0;
                starve = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
